// File: rtl/ti_sbox_round_seq.sv
// Round sequencer for a 2-share threshold-implementation S-box: holds the shared
// state, feeds it to an external component-function bank and recaptures its result.
module ti_sbox_round_seq #(
  parameter int unsigned NUM_ROUNDS = 3,
  parameter bit          REMASK     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_share,
  output logic [15:0] comp_in,
  input  logic [15:0] comp_out,
  input  logic [7:0]  rnd_i,
  output logic        rnd_req,
  output logic [3:0]  round_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_share
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and the offered data stays put until taken.

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  round_q, round_d;
  logic        live_q;
  logic [15:0] mask;

  // Same byte on both shares keeps the unshared value intact.
  assign mask = REMASK ? {rnd_i, rnd_i} : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 16'h0000;
      round_q <= 4'h0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      round_q <= round_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    rnd_req   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // live_q keeps in_ready low until the first edge after reset release.
        in_ready = live_q;
        if (in_valid && live_q) begin
          data_d  = in_share;
          round_d = 4'h0;
          state_d = RUN;
        end
      end
      RUN: begin
        rnd_req = 1'b1;
        data_d  = comp_out ^ mask;
        if (round_q == LAST_ROUND) begin
          round_d = 4'h0;
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_share;
            round_d = 4'h0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign comp_in   = data_q;
  assign out_share = out_valid ? data_q : 16'h0000;
  assign round_o   = (state_q == RUN) ? round_q : 4'h0;

endmodule

// File: tb/tb_ti_sbox_round_seq.sv
// Bench for ti_sbox_round_seq: three builds (remasked, plain, single-round) driven
// with directed and random transactions, checked against a share-level model.
module tb_ti_sbox_round_seq;

  logic        clk, rst_n;
  logic        in_valid, out_ready;
  logic [15:0] in_share;
  logic [7:0]  rnd_i;

  logic        a_in_ready, a_rnd_req, a_out_valid;
  logic [15:0] a_comp_in, a_comp_out, a_out_share;
  logic [3:0]  a_round_o;
  logic        p_in_ready, p_rnd_req, p_out_valid;
  logic [15:0] p_comp_in, p_comp_out, p_out_share;
  logic [3:0]  p_round_o;

  logic        o_in_valid, o_out_ready, o_in_ready, o_rnd_req, o_out_valid;
  logic [15:0] o_in_share, o_comp_in, o_comp_out, o_out_share;
  logic [3:0]  o_round_o;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] last_p;

  assign a_comp_out = a_comp_in ^ 16'h0101;
  assign p_comp_out = p_comp_in ^ 16'h0101;
  assign o_comp_out = ~o_comp_in;

  ti_sbox_round_seq #(.NUM_ROUNDS(3), .REMASK(1'b1)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_share(in_share), .comp_in(a_comp_in), .comp_out(a_comp_out), .rnd_i(rnd_i),
    .rnd_req(a_rnd_req), .round_o(a_round_o), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_share(a_out_share));

  ti_sbox_round_seq #(.NUM_ROUNDS(3), .REMASK(1'b0)) u_plain (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p_in_ready),
    .in_share(in_share), .comp_in(p_comp_in), .comp_out(p_comp_out), .rnd_i(rnd_i),
    .rnd_req(p_rnd_req), .round_o(p_round_o), .out_valid(p_out_valid),
    .out_ready(out_ready), .out_share(p_out_share));

  ti_sbox_round_seq #(.NUM_ROUNDS(1), .REMASK(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_share(o_in_share), .comp_in(o_comp_in), .comp_out(o_comp_out), .rnd_i(rnd_i),
    .rnd_req(o_rnd_req), .round_o(o_round_o), .out_valid(o_out_valid),
    .out_ready(o_out_ready), .out_share(o_out_share));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Share-level reference: n bank applications, each optionally followed by
  // XORing that round's mask byte into both shares. rr[7:0] is round 0's byte.
  function automatic logic [15:0] model(input logic [15:0] x, input int n,
                                        input bit remask, input bit inv,
                                        input logic [31:0] rr);
    logic [15:0] v;
    logic [7:0]  r;
    v = x;
    for (int i = 0; i < n; i++) begin
      v = inv ? ~v : (v ^ 16'h0101);
      r = rr[8*i +: 8];
      if (remask) v = v ^ {r, r};
    end
    return v;
  endfunction

  function automatic logic [7:0] unshare(input logic [15:0] v);
    return v[7:0] ^ v[15:8];
  endfunction

  task automatic wait_ready(input string tag);
    int waited;
    waited = 0;
    while (!a_in_ready && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    check(tag, a_in_ready, 1);
  endtask

  // Driver: one full transaction through the remasked and plain builds.
  task automatic txn(input logic [15:0] x, input int stall, input bit fixed_rnd);
    logic [31:0] rr;
    logic [15:0] exp_a, exp_p;
    int rreq_cnt;
    rr = fixed_rnd ? 32'h000F_C35A : $urandom;
    wait_ready("txn_ready");
    in_valid = 1'b1; in_share = x; out_ready = 1'b0; rnd_i = 8'($urandom);
    @(negedge clk);
    exp_a = model(x, 3, 1'b1, 1'b0, rr);
    exp_p = model(x, 3, 1'b0, 1'b0, rr);
    rreq_cnt = 0;
    for (int r = 0; r < 3; r++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_share = 16'($urandom);
      rnd_i = rr[8*r +: 8];
      #1;
      check("round_o", 32'(a_round_o), r);
      check("comp_in_a", a_comp_in, model(x, r, 1'b1, 1'b0, rr));
      check("comp_in_p", p_comp_in, model(x, r, 1'b0, 1'b0, rr));
      check("run_in_ready", a_in_ready, 0);
      check("run_out_valid", a_out_valid, 0);
      if (a_rnd_req) rreq_cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("rnd_req_cycles", rreq_cnt, 3);
    check("done_valid_a", a_out_valid, 1);
    check("done_valid_p", p_out_valid, 1);
    check("out_share_a", a_out_share, exp_a);
    check("out_share_p", p_out_share, exp_p);
    check("unshared_inv", unshare(a_out_share), unshare(p_out_share));
    check("done_rnd_req", a_rnd_req, 0);
    check("done_round_o", a_round_o, 0);
    check("done_in_ready", a_in_ready, 0);
    last_p = p_out_share;
    for (int s = 0; s < stall; s++) begin
      rnd_i = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      check("stall_share", a_out_share, exp_a);
      check("stall_valid", a_out_valid, 1);
      check("stall_in_ready", a_in_ready, 0);
      check("stall_rnd_req", a_rnd_req, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("done_ready_comb", a_in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("after_xfer_valid", a_out_valid, 0);
    check("after_xfer_share", a_out_share, 0);
    check("after_xfer_ready", a_in_ready, 1);
  endtask

  task automatic b2b();
    logic [7:0]  rh [0:11];
    int          out_k[$];
    int          acc_k[$];
    logic [15:0] out_v[$];
    int          acc;
    wait_ready("b2b_ready");
    in_valid = 1'b1; in_share = 16'h1111; out_ready = 1'b1; acc = 0;
    for (int k = 0; k < 11; k++) begin
      if (acc == 1) in_share = 16'h2222;
      if (acc == 2) in_valid = 1'b0;
      rh[k] = 8'($urandom);
      rnd_i = rh[k];
      #1;
      if (a_out_valid) begin
        out_k.push_back(k);
        out_v.push_back(a_out_share);
      end
      if (in_valid && a_in_ready) begin
        acc++;
        acc_k.push_back(k);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b_out_count", out_k.size(), 2);
    check("b2b_acc_count", acc_k.size(), 2);
    if (out_k.size() == 2 && acc_k.size() == 2) begin
      check("b2b_spacing", out_k[1] - out_k[0], 4);
      check("b2b_overlap", acc_k[1], out_k[0]);
      check("b2b_share0", out_v[0], model(16'h1111, 3, 1'b1, 1'b0, {8'h00, rh[3], rh[2], rh[1]}));
      check("b2b_share1", out_v[1], model(16'h2222, 3, 1'b1, 1'b0, {8'h00, rh[7], rh[6], rh[5]}));
    end
  endtask

  task automatic reset_mid_run();
    int seen;
    wait_ready("rst_ready");
    in_valid = 1'b1; in_share = 16'($urandom); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("rst_pre_round", a_round_o, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_rnd_req", a_rnd_req, 0);
    check("rst_comp_in", a_comp_in, 0);
    check("rst_out_share", a_out_share, 0);
    check("rst_round_o", a_round_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("rel_in_ready", a_in_ready, 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_out_valid || p_out_valid) seen++;
      @(negedge clk); #1;
    end
    check("rst_no_escape", seen, 0);
    out_ready = 1'b0;
  endtask

  task automatic one_round();
    int waited;
    waited = 0;
    while (!o_in_ready && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    check("one_ready", o_in_ready, 1);
    o_in_valid = 1'b1; o_in_share = 16'h00FF; o_out_ready = 1'b0;
    @(negedge clk);
    o_in_valid = 1'b0;
    #1;
    check("one_rnd_req", o_rnd_req, 1);
    check("one_round_o", o_round_o, 0);
    check("one_run_valid", o_out_valid, 0);
    check("one_comp_in", o_comp_in, 16'h00FF);
    @(negedge clk); #1;
    check("one_valid", o_out_valid, 1);
    check("one_share", o_out_share, 16'hFF00);
    check("one_share_model", o_out_share, model(16'h00FF, 1, 1'b0, 1'b1, 32'h0));
    check("one_done_rnd_req", o_rnd_req, 0);
    o_out_ready = 1'b1;
    @(negedge clk);
    o_out_ready = 1'b0;
    #1;
    check("one_after_valid", o_out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_share = 16'h0; rnd_i = 8'h0;
    o_in_valid = 1'b0; o_out_ready = 1'b0; o_in_share = 16'h0;
    #1;
    check("reset_in_ready", a_in_ready, 0);
    check("reset_out_valid", a_out_valid, 0);
    check("reset_rnd_req", a_rnd_req, 0);
    check("reset_comp_in", a_comp_in, 0);
    check("reset_out_share", a_out_share, 0);
    check("reset_round_o", a_round_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("release_in_ready", a_in_ready, 1);

    txn(16'h3CA5, 0, 1'b1);
    check("single_pass_plain", last_p, 16'h3DA4);
    txn(16'h5AA5, 5, 1'b0);
    b2b();
    reset_mid_run();
    one_round();
    for (int i = 0; i < 20; i++)
      txn(16'($urandom), int'($urandom_range(0, 3)), 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
